comp_driver: RTL and testbench

COMP_DRIVER -- requirements
Module: comp_driver

---
 rtl/comp_driver_if.sv | 33 +++
 rtl/comp_driver.sv | 129 ++++++++++++
 tb/tb_comp_driver.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/comp_driver_if.sv
// Bundle of request, comparator and response signals between comp_driver and its environment.
// The slave modport is the driver's view; master is the requester/comparator side.
interface comp_driver_if #(
   parameter int BW     = 8,
   parameter int CNT_BW = 16
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic [BW-1:0]     req_opA_i;
   logic [BW-1:0]     req_opB_i;
   logic [BW-1:0]     opA_o;
   logic [BW-1:0]     opB_o;
   logic              match_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic              rsp_match_o;
   logic              rsp_error_o;
   logic              clr_cnt_i;
   logic [CNT_BW-1:0] pass_cnt_o;
   logic [CNT_BW-1:0] fail_cnt_o;

   modport slave (
      input  req_valid_i, req_opA_i, req_opB_i, match_i, rsp_ready_i, clr_cnt_i,
      output req_ready_o, opA_o, opB_o, rsp_valid_o, rsp_match_o, rsp_error_o,
             pass_cnt_o, fail_cnt_o
   );

   modport master (
      output req_valid_i, req_opA_i, req_opB_i, match_i, rsp_ready_i, clr_cnt_i,
      input  req_ready_o, opA_o, opB_o, rsp_valid_o, rsp_match_o, rsp_error_o,
             pass_cnt_o, fail_cnt_o
   );
endinterface

// File: rtl/comp_driver.sv
// Comparator driver: presents one operand pair, samples match_i LAT cycles later,
// reports it over a valid/ready handshake and keeps saturating pass/fail tallies.
module comp_driver #(
   parameter int BW     = 8,
   parameter int LAT    = 1,
   parameter int CNT_BW = 16
) (
   input  logic         clock,
   input  logic         resetn,
   comp_driver_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      REPORT
   } state_t;

   localparam logic [3:0]        LAT_INIT = 4'(LAT);
   localparam logic [CNT_BW-1:0] CNT_MAX  = '1;
   localparam logic [CNT_BW-1:0] CNT_ONE  = CNT_BW'(1);

   state_t            state_q;
   state_t            state_d;
   logic [3:0]        wait_q;
   logic [BW-1:0]     op_a_q;
   logic [BW-1:0]     op_b_q;
   logic              expected_q;
   logic              rsp_match_q;
   logic              rsp_error_q;
   logic [CNT_BW-1:0] pass_q;
   logic [CNT_BW-1:0] fail_q;

   logic accept;
   logic sample;
   logic deliver;

   // NOTE: every signal driven here gets its default first, so no path leaves a latch.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      sample  = 1'b0;
      deliver = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid_i) begin
               accept  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (wait_q == 4'd0) begin
               sample  = 1'b1;
               state_d = REPORT;
            end
         end
         REPORT: begin
            if (bus.rsp_ready_i) begin
               deliver = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            wait_q <= LAT_INIT;
         end else if (state_q == WAIT && wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
         end
      end
   end

   // Operands persist after the response so the comparator input never glitches back to zero.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         op_a_q      <= '0;
         op_b_q      <= '0;
         expected_q  <= 1'b0;
         rsp_match_q <= 1'b0;
         rsp_error_q <= 1'b0;
      end else begin
         if (accept) begin
            op_a_q     <= bus.req_opA_i;
            op_b_q     <= bus.req_opB_i;
            expected_q <= (bus.req_opA_i == bus.req_opB_i);
         end
         if (sample) begin
            rsp_match_q <= bus.match_i;
            rsp_error_q <= (bus.match_i != expected_q);
         end
      end
   end

   // A clear coinciding with a handshake wins; the delivered response goes uncounted.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pass_q <= '0;
         fail_q <= '0;
      end else if (bus.clr_cnt_i) begin
         pass_q <= '0;
         fail_q <= '0;
      end else if (deliver) begin
         if (rsp_error_q) begin
            if (fail_q != CNT_MAX) fail_q <= fail_q + CNT_ONE;
         end else begin
            if (pass_q != CNT_MAX) pass_q <= pass_q + CNT_ONE;
         end
      end
   end

   assign bus.req_ready_o = (state_q == IDLE);
   assign bus.rsp_valid_o = (state_q == REPORT);
   assign bus.opA_o       = op_a_q;
   assign bus.opB_o       = op_b_q;
   assign bus.rsp_match_o = rsp_match_q;
   assign bus.rsp_error_o = rsp_error_q;
   assign bus.pass_cnt_o  = pass_q;
   assign bus.fail_cnt_o  = fail_q;

endmodule

// File: tb/tb_comp_driver.sv
// Directed bench for comp_driver: three instances (LAT=1/CNT_BW=2, LAT=3, LAT=0) driven
// step by step, with expected responses queued at request time and popped on rsp_valid.
module tb_comp_driver;

   localparam int          N_DUT     = 3;
   localparam int          LAT_OF[3] = '{1, 3, 0};
   localparam int unsigned CMAX[3]   = '{3, 65535, 65535};

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic       tb_valid [N_DUT];
   logic       tb_match [N_DUT];
   logic       tb_rready[N_DUT];
   logic       tb_clr   [N_DUT];
   logic [7:0] tb_a     [N_DUT];
   logic [7:0] tb_b     [N_DUT];

   logic        o_ready [N_DUT];
   logic        o_rvalid[N_DUT];
   logic        o_rmatch[N_DUT];
   logic        o_rerror[N_DUT];
   logic [7:0]  o_opa   [N_DUT];
   logic [7:0]  o_opb   [N_DUT];
   logic [15:0] o_pass  [N_DUT];
   logic [15:0] o_fail  [N_DUT];

   int n_cmp  = 0;
   int n_fail = 0;

   logic [1:0]  sb_q[N_DUT][$];
   logic        cur_m[N_DUT];
   logic [7:0]  cur_a[N_DUT];
   logic [7:0]  cur_b[N_DUT];
   int unsigned exp_pass[N_DUT];
   int unsigned exp_fail[N_DUT];

   for (genvar g = 0; g < N_DUT; g++) begin : gen_dut
      localparam int CW = (g == 0) ? 2 : 16;
      comp_driver_if #(.BW(8), .CNT_BW(CW)) bus ();
      comp_driver #(.BW(8), .LAT(LAT_OF[g]), .CNT_BW(CW)) u_dut (
         .clock (clk),
         .resetn(resetn),
         .bus   (bus)
      );
      assign bus.req_valid_i = tb_valid[g];
      assign bus.req_opA_i   = tb_a[g];
      assign bus.req_opB_i   = tb_b[g];
      assign bus.match_i     = tb_match[g];
      assign bus.rsp_ready_i = tb_rready[g];
      assign bus.clr_cnt_i   = tb_clr[g];
      assign o_ready[g]      = bus.req_ready_o;
      assign o_rvalid[g]     = bus.rsp_valid_o;
      assign o_rmatch[g]     = bus.rsp_match_o;
      assign o_rerror[g]     = bus.rsp_error_o;
      assign o_opa[g]        = bus.opA_o;
      assign o_opb[g]        = bus.opB_o;
      assign o_pass[g]       = 16'(bus.pass_cnt_o);
      assign o_fail[g]       = 16'(bus.fail_cnt_o);
   end

   task automatic check(input int d, input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL d%0d %s: observed=%0h expected=%0h", d, tag, obs, exp);
      end
   endtask

   task automatic accept(input int d, input logic [7:0] a, input logic [7:0] b,
                         input bit fault, input bit keep);
      logic m;
      m = fault ? (a != b) : (a == b);
      sb_q[d].push_back({m, fault});
      cur_m[d] = m;
      cur_a[d] = a;
      cur_b[d] = b;
      @(negedge clk);
      tb_a[d]     = a;
      tb_b[d]     = b;
      tb_valid[d] = 1'b1;
      tb_match[d] = ~m;
      check(d, "ready_idle", o_ready[d], 1);
      @(posedge clk); #1;
      if (!keep) tb_valid[d] = 1'b0;
      tb_a[d] = ~a;
      tb_b[d] = ~b;
      check(d, "op_a_load", o_opa[d], a);
      check(d, "op_b_load", o_opb[d], b);
      check(d, "ready_busy", o_ready[d], 0);
   endtask

   task automatic respond(input int d, input int hold, input bit clr);
      logic [1:0] rsp;
      logic       m;
      m = cur_m[d];
      for (int k = 0; k <= LAT_OF[d]; k++) begin
         @(negedge clk);
         tb_match[d] = (k == LAT_OF[d]) ? m : ~m;
         check(d, "no_rsp_early", o_rvalid[d], 0);
         @(posedge clk); #1;
      end
      tb_match[d] = ~m;
      check(d, "rsp_valid", o_rvalid[d], 1);
      rsp = sb_q[d].pop_front();
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         tb_match[d] = ~tb_match[d];
         @(posedge clk); #1;
         check(d, "rsp_valid_hold", o_rvalid[d], 1);
         check(d, "rsp_match_hold", o_rmatch[d], rsp[1]);
         check(d, "rsp_error_hold", o_rerror[d], rsp[0]);
         check(d, "ready_report", o_ready[d], 0);
      end
      @(negedge clk);
      tb_rready[d] = 1'b1;
      tb_clr[d]    = clr;
      check(d, "rsp_match", o_rmatch[d], rsp[1]);
      check(d, "rsp_error", o_rerror[d], rsp[0]);
      check(d, "op_a_hold", o_opa[d], cur_a[d]);
      check(d, "op_b_hold", o_opb[d], cur_b[d]);
      @(posedge clk); #1;
      tb_rready[d] = 1'b0;
      tb_clr[d]    = 1'b0;
      if (clr) begin
         exp_pass[d] = 0;
         exp_fail[d] = 0;
      end else if (rsp[0]) begin
         if (exp_fail[d] < CMAX[d]) exp_fail[d]++;
      end else begin
         if (exp_pass[d] < CMAX[d]) exp_pass[d]++;
      end
      check(d, "pass_cnt", o_pass[d], exp_pass[d]);
      check(d, "fail_cnt", o_fail[d], exp_fail[d]);
      check(d, "rsp_valid_done", o_rvalid[d], 0);
      check(d, "ready_done", o_ready[d], 1);
   endtask

   initial begin
      resetn = 1'b0;
      for (int i = 0; i < N_DUT; i++) begin
         tb_valid[i]  = 1'b0;
         tb_match[i]  = 1'b0;
         tb_rready[i] = 1'b0;
         tb_clr[i]    = 1'b0;
         tb_a[i]      = 8'h00;
         tb_b[i]      = 8'h00;
         exp_pass[i]  = 0;
         exp_fail[i]  = 0;
      end
      #1;
      for (int i = 0; i < N_DUT; i++) begin
         check(i, "rst_ready", o_ready[i], 1);
         check(i, "rst_rsp_valid", o_rvalid[i], 0);
         check(i, "rst_op_a", o_opa[i], 0);
         check(i, "rst_op_b", o_opb[i], 0);
         check(i, "rst_pass", o_pass[i], 0);
         check(i, "rst_fail", o_fail[i], 0);
      end

      // Release mid-cycle; the first rising edge afterwards must accept.
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;

      // Reset pulse while the LAT=3 instance is in WAIT drops the transaction.
      accept(1, 8'h12, 8'h34, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check(1, "midrst_op_a", o_opa[1], 0);
      check(1, "midrst_op_b", o_opb[1], 0);
      check(1, "midrst_rsp_valid", o_rvalid[1], 0);
      check(1, "midrst_rsp_match", o_rmatch[1], 0);
      check(1, "midrst_rsp_error", o_rerror[1], 0);
      check(1, "midrst_ready", o_ready[1], 1);
      sb_q[1].delete();
      @(posedge clk);
      #2 resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check(1, "postrst_no_rsp", o_rvalid[1], 0);
         check(1, "postrst_ready", o_ready[1], 1);
      end
      check(1, "postrst_pass", o_pass[1], 0);
      check(1, "postrst_fail", o_fail[1], 0);

      // LAT=1: healthy comparator on equal operands, then faulty one on unequal operands.
      accept(0, 8'h5A, 8'h5A, 1'b0, 1'b0);
      respond(0, 0, 1'b0);
      accept(0, 8'h5A, 8'h5B, 1'b1, 1'b0);
      respond(0, 0, 1'b0);

      // LAT=3 with a stalled response and req_valid held high throughout.
      accept(1, 8'hC3, 8'hC3, 1'b0, 1'b1);
      respond(1, 5, 1'b0);
      accept(1, 8'h77, 8'h78, 1'b0, 1'b0);
      respond(1, 0, 1'b0);

      // LAT=0 with match_i toggling around the single sampling cycle.
      accept(2, 8'hAA, 8'hAA, 1'b0, 1'b0);
      respond(2, 2, 1'b0);
      accept(2, 8'h0F, 8'hF0, 1'b0, 1'b0);
      respond(2, 1, 1'b0);
      accept(2, 8'h33, 8'h33, 1'b1, 1'b0);
      respond(2, 0, 1'b0);
      accept(2, 8'h81, 8'h18, 1'b1, 1'b0);
      respond(2, 3, 1'b0);

      // CNT_BW=2: four more passes saturate at 3; a clear on the next handshake wins.
      for (int i = 0; i < 4; i++) begin
         accept(0, 8'(i * 37 + 1), 8'(i * 37 + 1), 1'b0, 1'b0);
         respond(0, i % 2, 1'b0);
      end
      accept(0, 8'hFF, 8'hFF, 1'b0, 1'b0);
      respond(0, 1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
